// File: rtl/bcd_digit_packer_pkg.sv
// Shared definitions for the BCD digit packer: FSM states, digit/value limits
// and small classification helpers.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ONE_DIGIT = 2'd1,
        FULL      = 2'd2
    } bcd_state_e;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [7:0] BCD_MAX_PACKED = 8'h15;

    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= BCD_MAX_DIGIT);
    endfunction

    // The next stage only handles results that fit a 4-bit binary value.
    function automatic logic bcd_packed_in_range(input logic [7:0] value);
        return (value <= BCD_MAX_PACKED);
    endfunction

endpackage

// File: rtl/bcd_digit_packer.sv
// Packs one or two incoming BCD digits (MSD first) into an 8-bit {tens,ones} value.
// Optional macro BCD_RANGE_CHECK_EN rejects packed values above 8'h15.
module bcd_digit_packer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic [7:0] bcd_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);
    import bcd_pkg::*;

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    bcd_state_e         state_q, state_d;
    logic [3:0]         held_q, held_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         bcd_q, bcd_d;
    logic               err_q, err_d;
    logic               digit_ready_q, digit_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               digit_take_s;
    logic               out_take_s;
    logic               digit_ok_s;
    logic [7:0]         pack_s;
    logic               range_ok_s;

    // Handshakes and the candidate value that would be packed this cycle.
    always_comb begin
        digit_take_s = digit_valid & digit_ready_q;
        out_take_s   = out_valid_q & out_ready;
        digit_ok_s   = bcd_digit_ok(digit_in);
        if (digit_take_s) begin
            pack_s = {held_q, digit_in};
        end else begin
            pack_s = {4'h0, held_q};
        end
`ifdef BCD_RANGE_CHECK_EN
        range_ok_s = bcd_packed_in_range(pack_s);
`else
        range_ok_s = 1'b1;
`endif
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        timer_d = timer_q;
        bcd_d   = bcd_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (digit_take_s) begin
                    if (digit_ok_s) begin
                        held_d  = digit_in;
                        timer_d = '0;
                        state_d = ONE_DIGIT;
                    end else begin
                        err_d   = 1'b1;
                        held_d  = 4'h0;
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ONE_DIGIT: begin
                // A digit arriving on the timeout cycle wins over the timeout.
                if (digit_take_s) begin
                    timer_d = '0;
                    if (digit_ok_s && range_ok_s) begin
                        bcd_d   = pack_s;
                        state_d = FULL;
                    end else begin
                        err_d   = 1'b1;
                        held_d  = 4'h0;
                        state_d = IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (range_ok_s) begin
                        bcd_d   = pack_s;
                        state_d = FULL;
                    end else begin
                        err_d   = 1'b1;
                        held_d  = 4'h0;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + {{(TIMER_W-1){1'b0}}, 1'b1};
                    state_d = ONE_DIGIT;
                end
            end
            FULL: begin
                if (out_take_s) begin
                    held_d  = 4'h0;
                    state_d = IDLE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                held_d  = 4'h0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
        digit_ready_d = (state_d != FULL);
        out_valid_d   = (state_d == FULL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            held_q        <= 4'h0;
            timer_q       <= '0;
            bcd_q         <= 8'h00;
            err_q         <= 1'b0;
            digit_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            timer_q       <= timer_d;
            bcd_q         <= bcd_d;
            err_q         <= err_d;
            digit_ready_q <= digit_ready_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign digit_ready = digit_ready_q;
    assign bcd_out     = bcd_q;
    assign out_valid   = out_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Directed self-checking bench for bcd_digit_packer (TIMEOUT_CYCLES = 16).
module tb_bcd_digit_packer;

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic [7:0] bcd_out;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    int n_cmp;
    int n_bad;

    bcd_digit_packer #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .bcd_out    (bcd_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_ready"}, {31'd0, digit_ready}, 32'd1);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        digit_in    = 4'h0;
        digit_valid = 1'b0;
        out_ready   = 1'b1;
        step();
        step();
        check_val("rst_bcd",   {24'd0, bcd_out}, 32'h00);
        check_val("rst_err",   {31'd0, err}, 32'd0);
        check_idle("rst");
        rst = 1'b0;
        step();

        // Two back-to-back digits
        digit_in = 4'h1; digit_valid = 1'b1;
        step();
        check_val("d12_mid_valid", {31'd0, out_valid}, 32'd0);
        digit_in = 4'h2;
        step();
        digit_valid = 1'b0;
        check_val("d12_valid", {31'd0, out_valid}, 32'd1);
        check_val("d12_bcd",   {24'd0, bcd_out}, 32'h12);
        check_val("d12_ready", {31'd0, digit_ready}, 32'd0);
        step();
        check_idle("d12_after");

        // Single digit times out after 16 idle cycles
        send(4'h7);
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check_val("to_early_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_val("to_valid", {31'd0, out_valid}, 32'd1);
        check_val("to_bcd",   {24'd0, bcd_out}, 32'h07);
        step();
        check_idle("to_after");

        // Illegal second digit
        send(4'h4);
        send(4'hA);
        check_val("bad2_err", {31'd0, err}, 32'd1);
        check_idle("bad2");
        step();
        check_val("bad2_err_end", {31'd0, err}, 32'd0);

        // Illegal first digit
        send(4'hF);
        check_val("bad1_err", {31'd0, err}, 32'd1);
        check_idle("bad1");
        step();
        check_val("bad1_err_end", {31'd0, err}, 32'd0);

        // 19: rejected by the range check, passed otherwise
        send(4'h1);
        send(4'h9);
`ifdef BCD_RANGE_CHECK_EN
        check_val("d19_err",   {31'd0, err}, 32'd1);
        check_val("d19_valid", {31'd0, out_valid}, 32'd0);
`else
        check_val("d19_err",   {31'd0, err}, 32'd0);
        check_val("d19_valid", {31'd0, out_valid}, 32'd1);
        check_val("d19_bcd",   {24'd0, bcd_out}, 32'h19);
`endif
        step();
        check_idle("d19_after");

        // 15 is the largest value allowed in either build
        send(4'h1);
        send(4'h5);
        check_val("d15_valid", {31'd0, out_valid}, 32'd1);
        check_val("d15_bcd",   {24'd0, bcd_out}, 32'h15);
        step();

        // Backpressure: value held stable, digits ignored
        out_ready = 1'b0;
        send(4'h1);
        send(4'h3);
        digit_in = 4'h5; digit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_ready", {31'd0, digit_ready}, 32'd0);
            check_val("bp_bcd",   {24'd0, bcd_out}, 32'h13);
            check_val("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        digit_valid = 1'b0;
        out_ready   = 1'b1;
        step();
        check_idle("bp_after");
        check_val("bp_keep_bcd", {24'd0, bcd_out}, 32'h13);

        // Digit arriving on the timeout cycle wins
        send(4'h8);
        for (int i = 0; i < 15; i++) begin
            step();
        end
        send(4'h3);
`ifdef BCD_RANGE_CHECK_EN
        check_val("tie_err",   {31'd0, err}, 32'd1);
        check_val("tie_valid", {31'd0, out_valid}, 32'd0);
`else
        check_val("tie_valid", {31'd0, out_valid}, 32'd1);
        check_val("tie_bcd",   {24'd0, bcd_out}, 32'h83);
`endif
        step();
        check_idle("tie_after");

        // Reset mid-cycle while one digit is held
        send(4'h6);
        #2;
        rst = 1'b1;
        #1;
        check_val("mrst_bcd", {24'd0, bcd_out}, 32'h00);
        check_val("mrst_err", {31'd0, err}, 32'd0);
        check_idle("mrst");
        step();
        rst = 1'b0;
        send(4'h0);
        send(4'h5);
        check_val("mrst_valid", {31'd0, out_valid}, 32'd1);
        check_val("mrst_05",    {24'd0, bcd_out}, 32'h05);
        step();
        check_idle("mrst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
